fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the branch predictor's PC output and the ID stage. It issues in-order word fetches to the instruction memory port and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents one instruction per cycle to ID under the pipeline enable. On a redirect it flushes all buffered and in-flight fetches and restarts at the new PC.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight requests combined; power of two, 2..16
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch (from pred / EX mispredict)
- redirect_pc  in  32  restart address; bits [1:0] ignored and treated as 0
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  32  word-aligned fetch address
- resp_valid  in  1  fetch data returning, in request order
- resp_data  in  32  instruction word
- inst_valid  out  1  head entry valid toward ID
- inst  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- pipeline_en  in  1  ID consumes head when inst_valid && pipeline_en

## Operation
- State: fetch_pc, FIFO (head/tail pointers with an extra wrap bit), inflight count, drop count.
- Request: req_valid = !redirect_valid && (fifo_count + inflight < DEPTH). req_addr = fetch_pc.
- On req_valid && req_ready: fetch_pc += 4, wrapping mod 2^32; inflight += 1.
- req_addr is held stable while req_valid && !req_ready.
- Response with drop == 0: word is enqueued with its PC. A separate resp_pc register tracks each enqueued word's PC and advances by 4 per enqueue. inflight decrements.
- Response with drop > 0: word is discarded. drop decrements, inflight decrements.
- Dequeue: inst_valid && pipeline_en pops the head. inst and inst_pc are the registered head entry.
- FIFO never overflows, because responses are credit-limited by the request rule. A resp_valid with inflight == 0 is a protocol error and is ignored.
- Redirect cycle:
  - FIFO is emptied.
  - drop += inflight, minus any response arriving this cycle.
  - fetch_pc and resp_pc are set to {redirect_pc[31:2], 2'b00}.
  - req_valid is 0 that cycle; the earliest new request is the next cycle.
- Simultaneous events in the redirect cycle:
  - A response that cycle is dropped.
  - A dequeue that cycle has no effect on FIFO state.
  - A request handshake cannot occur.
- Simultaneous enqueue and dequeue: allowed at any occupancy, including full and empty. The count is unchanged.
- Pointer wrap: pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when all bits are equal.

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - req_valid=0, req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
  - inflight=0, drop=0, FIFO empty.
  - The first request is asserted the first cycle after reset deasserts.
- Reset asserted mid-operation: all state clears immediately. Responses returning after reset for pre-reset requests are the memory's responsibility; the memory port is reset by the same rst.
- Latency without bypass: resp_valid in cycle N gives inst_valid in cycle N+1.
- Throughput: one instruction per cycle sustained when memory returns one word per cycle and DEPTH >= round-trip + 1.
- Redirect at cycle N: inst_valid=0 at N+1; req_valid may be 1 at N+1 with req_addr = redirect_pc.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty, drop == 0 and resp_valid, then inst, inst_pc and inst_valid are driven combinationally from resp_data and resp_pc in the same cycle.
  - If pipeline_en is also 1, the word is consumed without enqueue.
  - Zero-cycle response-to-ID latency.
- FETCH_BYPASS_EN undefined: all outputs toward ID are registered from the FIFO head. One-cycle latency as in Timing.

## Test plan
- Reset release, req_ready=1, memory latency 1, pipeline_en=1 -> req_addr 0x80000000, 0x80000004, ... each cycle; inst_pc sequence matches, one instruction per cycle after the pipeline fills.
- pipeline_en=0 with memory always ready, DEPTH=4 -> exactly 4 requests accepted, then req_valid=0. Releasing pipeline_en yields 4 instructions in order, then fetch resumes at 0x80000010.
- Redirect to 0x80001002 with 3 requests in flight -> the next 3 responses are discarded, inst_valid=0 meanwhile, and the next req_addr is 0x80001000.
- Redirect in the same cycle as resp_valid and a dequeue -> response dropped, FIFO empty next cycle, drop == inflight - 1.
- redirect_pc=0xFFFFFFFC, memory ready -> req_addr sequence 0xFFFFFFFC, 0x00000000; inst_pc wraps identically.
- With FETCH_BYPASS_EN, FIFO empty, resp_valid=1 with resp_data=0x00000013 -> inst=0x00000013 and inst_valid=1 in the same cycle, and the FIFO stays empty.

Source files
------------

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue port bundle: redirect, memory request/response, ID-side instruction
interface fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        pipeline_en;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, pipeline_en,
    output req_valid, req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, pipeline_en,
    input  req_valid, req_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with redirect flush; FETCH_BYPASS_EN adds resp-to-ID bypass
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW:0]   head, tail, count;
  logic [AW:0]   inflight, drop_cnt;
  logic [31:0]   fetch_pc, resp_pc;
  logic [AW+1:0] credit_used;
  logic [31:0]   redir_pc;
  logic          fifo_empty, req_fire, resp_accept, good_resp, enq, deq;
  logic          bypass_hit, bypass_take;

  assign fifo_empty  = (head == tail);
  assign count       = tail - head;
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign redir_pc    = fq.redirect_pc & ~32'h3;

  // Held low during reset so the first request appears the cycle after release.
  assign fq.req_valid = rst && !fq.redirect_valid && (credit_used < DEPTH_C);
  assign fq.req_addr  = fetch_pc;
  assign req_fire     = fq.req_valid && fq.req_ready;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign resp_accept = fq.resp_valid && (inflight != '0);
  assign good_resp   = resp_accept && (drop_cnt == '0) && !fq.redirect_valid;
  assign deq         = !fifo_empty && fq.pipeline_en && !fq.redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit    = good_resp && fifo_empty;
  assign bypass_take   = bypass_hit && fq.pipeline_en;
  assign enq           = good_resp && !bypass_take;
  assign fq.inst_valid = !fifo_empty || bypass_hit;
  assign fq.inst       = bypass_hit ? fq.resp_data : mem_inst[head[AW-1:0]];
  assign fq.inst_pc    = bypass_hit ? resp_pc : mem_pc[head[AW-1:0]];
`else
  assign bypass_hit    = 1'b0;
  assign bypass_take   = 1'b0;
  assign enq           = good_resp;
  assign fq.inst_valid = !fifo_empty;
  assign fq.inst       = mem_inst[head[AW-1:0]];
  assign fq.inst_pc    = mem_pc[head[AW-1:0]];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (fq.redirect_valid) begin
      // Every response still outstanding after this cycle belongs to the old path.
      head     <= tail;
      fetch_pc <= redir_pc;
      resp_pc  <= redir_pc;
      inflight <= inflight - CW'(resp_accept);
      drop_cnt <= inflight - CW'(resp_accept);
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(resp_accept);
      if (resp_accept && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
      if (enq) begin
        mem_inst[tail[AW-1:0]] <= fq.resp_data;
        mem_pc[tail[AW-1:0]]   <= resp_pc;
        tail                   <= tail + 1'b1;
      end
      if (enq || bypass_take)
        resp_pc <= resp_pc + 32'd4;
      if (deq)
        head <= head + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a queued memory model
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if bus ();
  fetch_queue #(.DEPTH(4), .RESET_PC(32'h8000_0000)) dut (.clk(clk), .rst(rst), .fq(bus));

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        mem_hold;
  logic        s_req_valid, s_inst_valid, s_req_fire, s_resp_fire;
  logic [31:0] s_req_addr, s_inst, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a - 32'h7FFF_FFED;
  endfunction

  task automatic drive_mem();
    bus.resp_valid = !mem_hold && (mq.size() > 0);
    bus.resp_data  = (mq.size() > 0) ? mem_word(mq[0]) : 32'h0;
  endtask

  task automatic set_hold(input logic h);
    mem_hold = h;
    drive_mem();
  endtask

  task automatic cycle();
    #1;
    s_req_valid  = bus.req_valid;
    s_req_addr   = bus.req_addr;
    s_inst_valid = bus.inst_valid;
    s_inst       = bus.inst;
    s_inst_pc    = bus.inst_pc;
    s_req_fire   = bus.req_valid && bus.req_ready;
    s_resp_fire  = bus.resp_valid;
    if (s_req_fire) req_log.push_back(s_req_addr);
    if (bus.inst_valid && bus.pipeline_en && !bus.redirect_valid) begin
      got_pc.push_back(bus.inst_pc);
      got_inst.push_back(bus.inst);
    end
    @(posedge clk);
    #1;
    if (s_resp_fire && mq.size() > 0) void'(mq.pop_front());
    if (s_req_fire) mq.push_back(s_req_addr);
    drive_mem();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.req_ready      = 1'b1;
    bus.pipeline_en    = 1'b0;
    mq.delete();
    req_log.delete();
    got_pc.delete();
    got_inst.delete();
    set_hold(1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.req_valid); end
    checks++; if (bus.req_addr !== 32'h8000_0000) begin failures++; $display("FAIL reset_req_addr got=%h exp=80000000", bus.req_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc); end
    rst = 1'b1;
    cycle();
    checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin
      failures++; $display("FAIL reset_first_req got=%b/%h exp=1/80000000", s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_stream();
    logic exp_v1;
    int   exp_n;
`ifdef FETCH_BYPASS_EN
    exp_v1 = 1'b1; exp_n = 9;
`else
    exp_v1 = 1'b0; exp_n = 8;
`endif
    apply_reset();
    bus.pipeline_en = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (s_inst_valid !== exp_v1) begin failures++; $display("FAIL stream_latency got=%b exp=%b", s_inst_valid, exp_v1); end
    repeat (8) cycle();
    checks++; if (req_log.size() != 10) begin failures++; $display("FAIL stream_req_count got=%0d exp=10", req_log.size()); end
    checks++; if (got_pc.size() != exp_n) begin failures++; $display("FAIL stream_inst_count got=%0d exp=%0d", got_pc.size(), exp_n); end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'h8000_0000 + 32'(4 * i);
      checks++; if (req_log[i] !== pc) begin failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, req_log[i], pc); end
      checks++; if (got_pc[i] !== pc) begin failures++; $display("FAIL stream_inst_pc[%0d] got=%h exp=%h", i, got_pc[i], pc); end
      checks++; if (got_inst[i] !== mem_word(pc)) begin failures++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, got_inst[i], mem_word(pc)); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    rst = 1'b1;
    repeat (8) cycle();
    checks++; if (req_log.size() != 4) begin failures++; $display("FAIL stall_req_count got=%0d exp=4", req_log.size()); end
    checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", s_req_valid); end
    checks++; if (s_inst_valid !== 1'b1 || s_inst_pc !== 32'h8000_0000) begin
      failures++; $display("FAIL stall_head got=%b/%h exp=1/80000000", s_inst_valid, s_inst_pc);
    end
    bus.pipeline_en = 1'b1;
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc = 32'h8000_0000 + 32'(4 * i);
      checks++; if (got_pc[i] !== pc) begin failures++; $display("FAIL stall_drain_pc[%0d] got=%h exp=%h", i, got_pc[i], pc); end
    end
    checks++; if (req_log[4] !== 32'h8000_0010) begin failures++; $display("FAIL stall_resume_addr got=%h exp=80000010", req_log[4]); end
  endtask

  task automatic test_redirect();
    int seen;
    apply_reset();
    bus.pipeline_en = 1'b1;
    set_hold(1'b1);
    rst = 1'b1;
    repeat (3) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1002;
    cycle();
    checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL redirect_req_valid got=%b exp=0", s_req_valid); end
    bus.redirect_valid = 1'b0;
    set_hold(1'b0);
    seen = 0;
    repeat (3) begin
      cycle();
      if (s_inst_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL redirect_drop_window got=%0d exp=0", seen); end
    checks++; if (req_log[3] !== 32'h8000_1000) begin failures++; $display("FAIL redirect_new_addr got=%h exp=80001000", req_log[3]); end
    repeat (6) cycle();
    checks++; if (got_pc[0] !== 32'h8000_1000) begin failures++; $display("FAIL redirect_first_pc got=%h exp=80001000", got_pc[0]); end
    checks++; if (got_inst[0] !== mem_word(32'h8000_1000)) begin
      failures++; $display("FAIL redirect_first_inst got=%h exp=%h", got_inst[0], mem_word(32'h8000_1000));
    end
  endtask

  task automatic test_redirect_collide();
    apply_reset();
    rst = 1'b1;
    cycle();
    cycle();
    set_hold(1'b1);
    repeat (3) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    bus.pipeline_en    = 1'b1;
    set_hold(1'b0);
    cycle();
    checks++; if (dut.drop_cnt !== 3'd2) begin failures++; $display("FAIL collide_drop got=%0d exp=2", dut.drop_cnt); end
    checks++; if (dut.inflight !== 3'd2) begin failures++; $display("FAIL collide_inflight got=%0d exp=2", dut.inflight); end
    bus.redirect_valid = 1'b0;
    cycle();
    checks++; if (s_inst_valid !== 1'b0) begin failures++; $display("FAIL collide_empty got=%b exp=0", s_inst_valid); end
    repeat (6) cycle();
    checks++; if (got_pc[0] !== 32'h0000_2000) begin failures++; $display("FAIL collide_first_pc got=%h exp=00002000", got_pc[0]); end
  endtask

  task automatic test_wrap();
    int n, m;
    apply_reset();
    bus.pipeline_en = 1'b1;
    rst = 1'b1;
    repeat (4) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    n = req_log.size();
    m = got_pc.size();
    repeat (10) cycle();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc = 32'hFFFF_FFFC + 32'(4 * i);
      checks++; if (req_log[n+i] !== pc) begin failures++; $display("FAIL wrap_req_addr[%0d] got=%h exp=%h", i, req_log[n+i], pc); end
      checks++; if (got_pc[m+i] !== pc) begin failures++; $display("FAIL wrap_inst_pc[%0d] got=%h exp=%h", i, got_pc[m+i], pc); end
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    bus.pipeline_en = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (s_inst_valid !== 1'b1 || s_inst !== 32'h0000_0013) begin
      failures++; $display("FAIL bypass_same_cycle got=%b/%h exp=1/00000013", s_inst_valid, s_inst);
    end
    checks++; if (s_inst_pc !== 32'h8000_0000) begin failures++; $display("FAIL bypass_pc got=%h exp=80000000", s_inst_pc); end
    set_hold(1'b1);
    cycle();
    checks++; if (s_inst_valid !== 1'b0) begin failures++; $display("FAIL bypass_fifo_empty got=%b exp=0", s_inst_valid); end
    checks++; if (got_pc[0] !== 32'h8000_0000) begin failures++; $display("FAIL bypass_consumed got=%h exp=80000000", got_pc[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_wrap();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
